// File: rtl/ad9980_cfg_pkg.sv
// ad9980_cfg_pkg
// Shared types and constants for the AD9980 register-programming sequencer:
// sequencer state encoding, the register table entry layout and the fixed
// programming table itself (two data variants per register address).
package ad9980_cfg_pkg;

  localparam int NUM_REGS = 8;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } state_t;

  // data_lo is written for pixel clocks up to 65 MHz, data_hi above that.
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data_lo;
    logic [7:0] data_hi;
  } cfg_entry_t;

  // {reg_addr, data_lo, data_hi}
  localparam cfg_entry_t CFG_TABLE [NUM_REGS] = '{
    24'h015469,  // PLL divider MSBs
    24'h02D070,  // PLL divider LSBs
    24'h0348A8,  // VCO range / charge pump
    24'h048078,  // clock phase adjust
    24'h0B0204,  // clamp placement
    24'h121814,  // hsync control
    24'h1B0103,  // clamp / offset control
    24'h1E2020   // output / power control
  };

endpackage

// File: rtl/ad9980_cfg_seq_if.sv
// ad9980_cfg_seq_if
// Request/completion bus between the configuration sequencer and the
// byte-level I2C master.
//   Xfer_req              : request valid, driven by the sequencer
//   Xfer_dev/reg/data     : write fields, qualified by Xfer_req
//   Xfer_ack              : one-cycle pulse, master took the request
//   Xfer_done / Xfer_nack : one-cycle completion pulse and its status
//
// Handshake: Xfer_req is a valid that, once raised, stays high with all
// fields frozen until the cycle Xfer_ack is seen (Xfer_ack acts as the
// ready and only counts while Xfer_req=1); Xfer_req drops the next cycle.
// Exactly one Xfer_done follows each accepted request, possibly in the same
// cycle as Xfer_ack; Xfer_nack is only meaningful while Xfer_done=1.
interface ad9980_cfg_seq_if;
  logic       Xfer_req;
  logic [6:0] Xfer_dev;
  logic [7:0] Xfer_reg;
  logic [7:0] Xfer_data;
  logic       Xfer_ack;
  logic       Xfer_done;
  logic       Xfer_nack;

  // Sequencer side
  modport master (
    output Xfer_req, Xfer_dev, Xfer_reg, Xfer_data,
    input  Xfer_ack, Xfer_done, Xfer_nack
  );

  // I2C master side
  modport slave (
    input  Xfer_req, Xfer_dev, Xfer_reg, Xfer_data,
    output Xfer_ack, Xfer_done, Xfer_nack
  );
endinterface

// File: rtl/ad9980_cfg_rom.sv
// ad9980_cfg_rom
// Combinational lookup of the programming table.
//   idx      : entry index
//   variant  : 1 selects the high pixel-rate data byte
//   reg_addr : register address of the entry
//   data     : data byte for the selected variant
module ad9980_cfg_rom
  import ad9980_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             variant,
  output logic [7:0]       reg_addr,
  output logic [7:0]       data
);

  cfg_entry_t entry;

  always_comb begin
    entry    = CFG_TABLE[idx];
    reg_addr = entry.reg_addr;
    data     = variant ? entry.data_hi : entry.data_lo;
  end

endmodule

// File: rtl/ad9980_cfg_seq.sv
// ad9980_cfg_seq
// Walks the AD9980 register table after a power-up wait, issuing one I2C
// byte write per entry, retrying NACKed writes and reporting Done/Error.
//   Clk, Reset       : clock, synchronous active-high reset
//   Start            : level, begins a sequence from IDLE/DONE/ERROR
//   Pixel_clk_greater_than_65Mhz : table variant, latched on accepted Start
//   xfer             : request/completion bus to the I2C master
//   Busy/Done/Error  : sequence status (Done/Error drive GPIO_LED)
//   Fail_index       : entry that exhausted its retries, valid with Error
//   state_dbg        : current sequencer state
module ad9980_cfg_seq
  import ad9980_cfg_pkg::*;
#(
  parameter int         CLK_RATE_MHZ = 27,
  parameter int         PWR_WAIT_US  = 1000,
  parameter int         GAP_CYCLES   = 64,
  parameter int         MAX_RETRY    = 3,
  parameter logic [6:0] DEV_ADDR     = 7'h4C
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Pixel_clk_greater_than_65Mhz,
  ad9980_cfg_seq_if.master   xfer,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  output logic [IDX_W-1:0]   Fail_index,
  output state_t             state_dbg
);

  localparam int PWR_CNT = CLK_RATE_MHZ * PWR_WAIT_US;
  localparam int MAX_CNT = (PWR_CNT > GAP_CYCLES) ? PWR_CNT : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [2:0]       retry_q,   retry_d;
  logic             variant_q, variant_d;
  logic             req_q,     req_d;
  logic [7:0]       reg_q,     reg_d;
  logic [7:0]       data_q,    data_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             error_q,   error_d;
  logic [IDX_W-1:0] fail_q,    fail_d;

  logic       complete;
  logic [7:0] rom_reg;
  logic [7:0] rom_data;

  ad9980_cfg_rom u_rom (
    .idx      (idx_q),
    .variant  (variant_q),
    .reg_addr (rom_reg),
    .data     (rom_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    variant_d = variant_q;
    req_d     = req_q;
    reg_d     = reg_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    fail_d    = fail_q;
    complete  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          state_d   = ST_PWR_WAIT;
          cnt_d     = '0;
          idx_d     = '0;
          retry_d   = '0;
          variant_d = Pixel_clk_greater_than_65Mhz;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          fail_d    = '0;
        end
      end
      ST_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        // First ISSUE cycle loads the fields; they are not touched again
        // until the request has been acknowledged.
        if (!req_q) begin
          req_d  = 1'b1;
          reg_d  = rom_reg;
          data_d = rom_data;
        end else if (xfer.Xfer_ack) begin
          req_d = 1'b0;
          if (xfer.Xfer_done) begin
            complete = 1'b1;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (xfer.Xfer_done) begin
          complete = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion decision, reached from WAIT_DONE or directly from ISSUE
    // when the master acks and finishes in the same cycle.
    if (complete) begin
      if (!xfer.Xfer_nack) begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + 1'b1;
          retry_d = '0;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end else begin
        retry_d = retry_q + 1'b1;
        if (({1'b0, retry_q} + 4'd1) < RETRY_LIM) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          fail_d  = idx_q;
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_ERROR;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      variant_q <= 1'b0;
      req_q     <= 1'b0;
      reg_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      variant_q <= variant_d;
      req_q     <= req_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      fail_q    <= fail_d;
    end
  end

  assign xfer.Xfer_req  = req_q;
  assign xfer.Xfer_dev  = DEV_ADDR;
  assign xfer.Xfer_reg  = reg_q;
  assign xfer.Xfer_data = data_q;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign Error          = error_q;
  assign Fail_index     = fail_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_ad9980_cfg_seq.sv
// tb_ad9980_cfg_seq
// Drives ad9980_cfg_seq with a behavioural I2C-master responder and checks
// the write stream, timing and status against a table-walk reference model.
module tb_ad9980_cfg_seq;
  import ad9980_cfg_pkg::*;

  localparam int CLK_MHZ = 2;
  localparam int PWR_US  = 10;
  localparam int PWR     = CLK_MHZ * PWR_US;
  localparam int GAP     = 6;
  localparam int MAXR    = 3;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Pix;
  logic       Busy, Done, Error;
  logic [2:0] Fail_index;
  state_t     state_dbg;
  int         cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  ad9980_cfg_seq_if ifc ();

  ad9980_cfg_seq #(
    .CLK_RATE_MHZ (CLK_MHZ),
    .PWR_WAIT_US  (PWR_US),
    .GAP_CYCLES   (GAP),
    .MAX_RETRY    (MAXR),
    .DEV_ADDR     (7'h4C)
  ) dut (
    .Clk                          (Clk),
    .Reset                        (Reset),
    .Start                        (Start),
    .Pixel_clk_greater_than_65Mhz (Pix),
    .xfer                         (ifc),
    .Busy                         (Busy),
    .Done                         (Done),
    .Error                        (Error),
    .Fail_index                   (Fail_index),
    .state_dbg                    (state_dbg)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference copy of the programming table.
  logic [7:0] t_reg [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B, 8'h12, 8'h1B, 8'h1E};
  logic [7:0] t_lo  [8] = '{8'h54, 8'hD0, 8'h48, 8'h80, 8'h02, 8'h18, 8'h01, 8'h20};
  logic [7:0] t_hi  [8] = '{8'h69, 8'h70, 8'hA8, 8'h78, 8'h04, 8'h14, 8'h03, 8'h20};

  // ---------------- responder (I2C master model) ----------------
  int   ack_delay = 0;
  int   done_delay = 0;
  bit   zero_lat = 0;
  int   nack_plan [8];
  int   att [8];
  int   start_cyc = 0;
  int   last_done_cyc = 0;
  bit   first_xfer = 0;
  logic [7:0] rsp_reg, rsp_data;
  int   rsp_e;
  bit   rsp_n, rsp_abort;

  initial begin
    ifc.Xfer_ack  = 1'b0;
    ifc.Xfer_done = 1'b0;
    ifc.Xfer_nack = 1'b0;
    forever begin
      @(negedge Clk);
      if (ifc.Xfer_req && !Reset) begin
        rsp_reg  = ifc.Xfer_reg;
        rsp_data = ifc.Xfer_data;
        obs_q.push_back({rsp_reg, rsp_data});
        chk("dev_addr", 32'(ifc.Xfer_dev), 32'h4C);
        if (first_xfer) chk("pwr_latency", cyc - start_cyc, PWR + 2);
        else            chk("gap_latency", cyc - last_done_cyc, GAP + 2);
        first_xfer = 0;
        rsp_abort  = 0;
        for (int i = 0; i < ack_delay; i++) begin
          @(negedge Clk);
          if (Reset) begin
            rsp_abort = 1;
            break;
          end
          chk("hold_req_fields", {ifc.Xfer_req, ifc.Xfer_reg, ifc.Xfer_data},
              {1'b1, rsp_reg, rsp_data});
        end
        if (!rsp_abort) begin
          rsp_e = 0;
          for (int i = 0; i < 8; i++) if (t_reg[i] == rsp_reg) rsp_e = i;
          rsp_n = (att[rsp_e] < nack_plan[rsp_e]);
          att[rsp_e]++;
          ifc.Xfer_ack = 1'b1;
          if (zero_lat) begin
            ifc.Xfer_done = 1'b1;
            ifc.Xfer_nack = rsp_n;
            last_done_cyc = cyc;
          end
          @(negedge Clk);
          ifc.Xfer_ack  = 1'b0;
          ifc.Xfer_done = 1'b0;
          ifc.Xfer_nack = 1'b0;
          if (!zero_lat) begin
            repeat (done_delay) @(negedge Clk);
            ifc.Xfer_done = 1'b1;
            ifc.Xfer_nack = rsp_n;
            last_done_cyc = cyc;
            @(negedge Clk);
            ifc.Xfer_done = 1'b0;
            ifc.Xfer_nack = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver: one full sequence ----------------
  task automatic run_seq(input bit var_sel, input bit toggle_mid, input bit start_mid);
    bit exp_err;
    int exp_fail;
    int n;
    exp_q.delete();
    obs_q.delete();
    exp_err  = 0;
    exp_fail = 0;
    for (int i = 0; i < 8; i++) att[i] = 0;
    // Reference: each entry is written until it ACKs or MAXR attempts fail.
    for (int i = 0; i < 8; i++) begin
      n = (nack_plan[i] >= MAXR) ? MAXR : nack_plan[i] + 1;
      for (int a = 0; a < n; a++) exp_q.push_back({t_reg[i], var_sel ? t_hi[i] : t_lo[i]});
      if (nack_plan[i] >= MAXR) begin
        exp_err  = 1;
        exp_fail = i;
        break;
      end
    end

    @(negedge Clk);
    Pix        = var_sel;
    Start      = 1'b1;
    start_cyc  = cyc;
    first_xfer = 1;
    @(negedge Clk);
    Start = 1'b0;
    chk("busy_after_start", 32'(Busy), 32'd1);
    chk("status_cleared", {30'd0, Done, Error}, 32'd0);
    for (int k = 0; k < 5000 && !(Done || Error); k++) begin
      @(negedge Clk);
      if (toggle_mid && (k % 7 == 0)) Pix = ~Pix;
      if (start_mid) Start = (k == 40);
    end
    Start = 1'b0;
    chk("seq_end", 32'(Done || Error), 32'd1);
    chk("busy_at_end", 32'(Busy), 32'd0);
    repeat (3 * GAP + 20) @(negedge Clk);
    chk("xfer_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("xfer[%0d]", i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk("done", 32'(Done), 32'(!exp_err));
    chk("error", 32'(Error), 32'(exp_err));
    if (exp_err) chk("fail_index", 32'(Fail_index), exp_fail);
    chk("busy_idle", 32'(Busy), 32'd0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 8; i++) nack_plan[i] = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r;
    Reset = 1'b1;
    Start = 1'b0;
    Pix   = 1'b0;
    clear_plan();
    repeat (3) @(negedge Clk);
    chk("rst_req", 32'(ifc.Xfer_req), 32'd0);
    chk("rst_reg_data", {16'd0, ifc.Xfer_reg, ifc.Xfer_data}, 32'd0);
    chk("rst_dev", 32'(ifc.Xfer_dev), 32'h4C);
    chk("rst_status", {28'd0, Busy, Done, Error, 1'b0}, 32'd0);
    chk("rst_fail_index", 32'(Fail_index), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge Clk);
    Reset = 1'b0;

    // Both variants, all ACKed; second one toggles the select mid-run.
    run_seq(1'b1, 1'b0, 1'b0);
    run_seq(1'b0, 1'b1, 1'b0);

    // Entry 3 NACKs twice then ACKs.
    clear_plan();
    nack_plan[3] = 2;
    run_seq(1'b1, 1'b0, 1'b0);

    // Entry 5 always NACKs.
    clear_plan();
    nack_plan[5] = 100;
    run_seq(1'b0, 1'b0, 1'b0);

    // Reset while a request is waiting for its ack.
    clear_plan();
    ack_delay = 30;
    @(negedge Clk);
    Pix        = 1'b1;
    Start      = 1'b1;
    start_cyc  = cyc;
    first_xfer = 1;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k < 200 && !ifc.Xfer_req; k++) @(negedge Clk);
    chk("req_before_reset", 32'(ifc.Xfer_req), 32'd1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("reset_mid_req", 32'(ifc.Xfer_req), 32'd0);
    chk("reset_mid_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    ack_delay = 0;
    run_seq(1'b1, 1'b0, 1'b0);

    // Slow ack with a Start pulse while busy.
    ack_delay = 20;
    run_seq(1'b1, 1'b0, 1'b1);
    ack_delay = 0;

    // Zero-latency master: ack and done together.
    zero_lat = 1;
    nack_plan[6] = 1;
    run_seq(1'b0, 1'b0, 1'b0);
    zero_lat = 0;

    // Randomised runs.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 19);
        nack_plan[i] = (r < 14) ? 0 : (r < 17) ? 1 : (r < 19) ? 2 : MAXR;
      end
      ack_delay  = $urandom_range(0, 4);
      done_delay = $urandom_range(0, 4);
      zero_lat   = ($urandom_range(0, 3) == 0);
      if (zero_lat) ack_delay = 0;
      run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
